// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - machine-mode trap/mret CSR write sequencer with PC redirect
//
// Accepts one of: synchronous exception, mret, external or timer interrupt
// (in that priority order, sampled only while idle), then walks the CSR file's
// single write port one register per cycle and finishes with a PC redirect.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   exc_valid/code/pc/tval        synchronous exception request from commit
//   mret_valid                    mret committed
//   irq_external, irq_timer       level interrupts
//   next_pc                       resume PC used as mepc for interrupts
//   csr_mstatus, csr_mie_*,       current CSR values (sampled at acceptance)
//   csr_mtvec, csr_mepc
//   csr_we/waddr/wdata            CSR write port (registered)
//   trap_ack, mret_ack            one-cycle acceptance pulses
//   redirect_valid, redirect_pc   fetch redirect (registered)
//   busy                          pipeline hold while a sequence is in flight
module trap_sequencer #(
   parameter int XLEN     = 32,
   parameter bit MTVAL_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            exc_valid,
   input  logic [3:0]      exc_code,
   input  logic [XLEN-1:0] exc_pc,
   input  logic [XLEN-1:0] exc_tval,
   input  logic            mret_valid,
   input  logic            irq_external,
   input  logic            irq_timer,
   input  logic [XLEN-1:0] next_pc,
   input  logic [XLEN-1:0] csr_mstatus,
   input  logic            csr_mie_meie,
   input  logic            csr_mie_mtie,
   input  logic [XLEN-1:0] csr_mtvec,
   input  logic [XLEN-1:0] csr_mepc,
   output logic            csr_we,
   output logic [11:0]     csr_waddr,
   output logic [XLEN-1:0] csr_wdata,
   output logic            trap_ack,
   output logic            mret_ack,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            busy
);

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
   localparam logic [11:0] ADDR_MTVAL   = 12'h343;

   localparam logic [XLEN-1:0] CAUSE_EXT = {1'b1, {(XLEN-5){1'b0}}, 4'hB};
   localparam logic [XLEN-1:0] CAUSE_TMR = {1'b1, {(XLEN-5){1'b0}}, 4'h7};

   typedef enum logic [2:0] {
      IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, REDIRECT, R_MSTATUS
   } state_t;

   state_t state_q, state_d;

   logic [XLEN-1:0] cause_q, tval_q, mstatus_q, target_q;

   logic            take_ext, take_tmr, take_trap, take_mret;
   logic            capture_trap, capture_mret;
   logic [XLEN-1:0] cause_in, epc_src, epc_in, tval_in, base, target_in;
   logic [XLEN-1:0] mstatus_trap, mstatus_mret;

   logic            we_d, tack_d, mack_d, rv_d;
   logic [11:0]     waddr_d;
   logic [XLEN-1:0] wdata_d, rpc_d;

   // Interrupt enables are judged against the mstatus seen while idle; the
   // trap itself clears MIE so a held level cannot re-trigger immediately.
   assign take_ext  = irq_external & csr_mstatus[3] & csr_mie_meie;
   assign take_tmr  = irq_timer & csr_mstatus[3] & csr_mie_mtie;
   // An exception beats a simultaneous mret; the mret is flushed upstream.
   assign take_trap = exc_valid | (~mret_valid & (take_ext | take_tmr));
   assign take_mret = ~exc_valid & mret_valid;

   assign capture_trap = (state_q == IDLE) & take_trap;
   assign capture_mret = (state_q == IDLE) & take_mret;

   assign cause_in = exc_valid ? {{(XLEN-4){1'b0}}, exc_code}
                   : (take_ext ? CAUSE_EXT : CAUSE_TMR);
   assign epc_src  = exc_valid ? exc_pc : next_pc;
   assign epc_in   = {epc_src[XLEN-1:2], 2'b00};
   assign tval_in  = exc_valid ? exc_tval : '0;
   assign base     = {csr_mtvec[XLEN-1:2], 2'b00};
   // Vectored mode only offsets interrupts; exceptions always land on base.
   assign target_in = (!exc_valid && csr_mtvec[1:0] == 2'b01)
                    ? base + {{(XLEN-6){1'b0}}, cause_in[3:0], 2'b00}
                    : base;

   always_comb begin
      mstatus_trap        = csr_mstatus;
      mstatus_trap[7]     = csr_mstatus[3];
      mstatus_trap[3]     = 1'b0;
      mstatus_trap[12:11] = 2'b11;
      mstatus_mret        = csr_mstatus;
      mstatus_mret[3]     = csr_mstatus[7];
      mstatus_mret[7]     = 1'b1;
      mstatus_mret[12:11] = 2'b11;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state plus the registered output values for the state being entered.
   always_comb begin
      state_d = state_q;
      we_d    = 1'b0;
      waddr_d = csr_waddr;
      wdata_d = csr_wdata;
      tack_d  = 1'b0;
      mack_d  = 1'b0;
      rv_d    = 1'b0;
      rpc_d   = redirect_pc;
      case (state_q)
         IDLE: begin
            if (take_trap) begin
               state_d = W_MEPC;
               we_d    = 1'b1;
               waddr_d = ADDR_MEPC;
               wdata_d = epc_in;
               tack_d  = 1'b1;
            end else if (take_mret) begin
               state_d = R_MSTATUS;
               we_d    = 1'b1;
               waddr_d = ADDR_MSTATUS;
               wdata_d = mstatus_mret;
               mack_d  = 1'b1;
            end
         end
         W_MEPC: begin
            state_d = W_MCAUSE;
            we_d    = 1'b1;
            waddr_d = ADDR_MCAUSE;
            wdata_d = cause_q;
         end
         W_MCAUSE: begin
            we_d = 1'b1;
            if (MTVAL_EN) begin
               state_d = W_MTVAL;
               waddr_d = ADDR_MTVAL;
               wdata_d = tval_q;
            end else begin
               state_d = W_MSTATUS;
               waddr_d = ADDR_MSTATUS;
               wdata_d = mstatus_q;
            end
         end
         W_MTVAL: begin
            state_d = W_MSTATUS;
            we_d    = 1'b1;
            waddr_d = ADDR_MSTATUS;
            wdata_d = mstatus_q;
         end
         W_MSTATUS, R_MSTATUS: begin
            state_d = REDIRECT;
            rv_d    = 1'b1;
            rpc_d   = target_q;
         end
         REDIRECT: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cause_q   <= '0;
         tval_q    <= '0;
         mstatus_q <= '0;
         target_q  <= '0;
      end else if (capture_trap) begin
         cause_q   <= cause_in;
         tval_q    <= tval_in;
         mstatus_q <= mstatus_trap;
         target_q  <= target_in;
      end else if (capture_mret) begin
         target_q  <= csr_mepc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csr_we         <= 1'b0;
         csr_waddr      <= '0;
         csr_wdata      <= '0;
         trap_ack       <= 1'b0;
         mret_ack       <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         csr_we         <= we_d;
         csr_waddr      <= waddr_d;
         csr_wdata      <= wdata_d;
         trap_ack       <= tack_d;
         mret_ack       <= mack_d;
         redirect_valid <= rv_d;
         redirect_pc    <= rpc_d;
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - self-checking bench for trap_sequencer
module tb_trap_sequencer;
   logic        clk = 1'b0;
   logic        rst;
   logic        exc_valid;
   logic [3:0]  exc_code;
   logic [31:0] exc_pc, exc_tval;
   logic        mret_valid, irq_external, irq_timer;
   logic [31:0] next_pc, csr_mstatus, csr_mtvec, csr_mepc;
   logic        csr_mie_meie, csr_mie_mtie;
   logic        csr_we;
   logic [11:0] csr_waddr;
   logic [31:0] csr_wdata;
   logic        trap_ack, mret_ack, redirect_valid;
   logic [31:0] redirect_pc;
   logic        busy;

   always #5 clk = ~clk;

   trap_sequencer #(.XLEN(32), .MTVAL_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval),
      .mret_valid(mret_valid), .irq_external(irq_external), .irq_timer(irq_timer),
      .next_pc(next_pc), .csr_mstatus(csr_mstatus), .csr_mie_meie(csr_mie_meie),
      .csr_mie_mtie(csr_mie_mtie), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
      .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
      .trap_ack(trap_ack), .mret_ack(mret_ack),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
   );

   // One expected output cycle of an in-flight sequence.
   typedef struct {
      bit          we;
      logic [11:0] addr;
      logic [31:0] data;
      bit          tack, mack, rv;
      logic [31:0] rpc;
   } exp_t;

   exp_t        q[$];
   int          n_vec = 0, n_err = 0, cyc = 0;
   logic [11:0] last_addr;
   logic [31:0] last_data, last_rpc;
   bit          model_idle, cur_we, acc_exc, acc_mret;
   logic [11:0] cur_addr;
   logic [31:0] cur_data;
   int          n_tack, n_mack, n_log, tack_cyc, mack_cyc, rv_cyc;
   logic [31:0] rv_pc;
   logic [11:0] log_addr[8];
   logic [31:0] log_data[8];
   logic [3:0]  codes[3] = '{4'd2, 4'd3, 4'd11};

   function automatic exp_t mk(input bit we, input logic [11:0] a, input logic [31:0] d,
                               input bit ta, input bit ma, input bit rv, input logic [31:0] pc);
      exp_t e;
      e.we = we; e.addr = a; e.data = d; e.tack = ta; e.mack = ma; e.rv = rv; e.rpc = pc;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_log();
      n_log = 0; n_tack = 0; n_mack = 0; tack_cyc = 0; mack_cyc = 0; rv_cyc = 0; rv_pc = '0;
   endtask

   // Compare DUT outputs against the model's expectation for this cycle.
   task automatic compare();
      exp_t e;
      bit   had;
      had = (q.size() > 0);
      if (had) e = q.pop_front();
      else     e = mk(1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      if (e.we) begin last_addr = e.addr; last_data = e.data; end
      if (e.rv) last_rpc = e.rpc;
      chk("busy",           32'(busy),           32'(had));
      chk("csr_we",         32'(csr_we),         32'(e.we));
      chk("csr_waddr",      32'(csr_waddr),      32'(last_addr));
      chk("csr_wdata",      csr_wdata,           last_data);
      chk("trap_ack",       32'(trap_ack),       32'(e.tack));
      chk("mret_ack",       32'(mret_ack),       32'(e.mack));
      chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
      chk("redirect_pc",    redirect_pc,         last_rpc);
      if (csr_we && n_log < 8) begin
         log_addr[n_log] = csr_waddr; log_data[n_log] = csr_wdata; n_log++;
      end
      if (trap_ack) begin n_tack++; tack_cyc = cyc; end
      if (mret_ack) begin n_mack++; mack_cyc = cyc; end
      if (redirect_valid) begin rv_cyc = cyc; rv_pc = redirect_pc; end
      cur_we = e.we; cur_addr = e.addr; cur_data = e.data;
      model_idle = !had;
   endtask

   // Reference model: from the request/CSR inputs about to be sampled, list
   // every output cycle the resulting sequence must produce.
   task automatic predict();
      logic [31:0] cause, epc, tval, base, tgt, ms;
      bit          trap, irq;
      if (rst || !model_idle) return;
      trap = 1'b0; irq = 1'b0;
      cause = '0; epc = '0; tval = '0;
      if (exc_valid) begin
         trap = 1'b1; cause = {28'h0, exc_code}; epc = exc_pc & ~32'h3; tval = exc_tval;
         acc_exc = 1'b1;
      end else if (mret_valid) begin
         ms = (csr_mstatus & ~32'h1888) | (csr_mstatus[7] ? 32'h8 : 32'h0) | 32'h1880;
         q.push_back(mk(1'b1, 12'h300, ms, 1'b0, 1'b1, 1'b0, 32'h0));
         q.push_back(mk(1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b1, csr_mepc));
         acc_mret = 1'b1; model_idle = 1'b0;
         return;
      end else if (csr_mstatus[3] && irq_external && csr_mie_meie) begin
         trap = 1'b1; irq = 1'b1; cause = 32'h8000000B;
      end else if (csr_mstatus[3] && irq_timer && csr_mie_mtie) begin
         trap = 1'b1; irq = 1'b1; cause = 32'h80000007;
      end
      if (!trap) return;
      if (irq) begin epc = next_pc & ~32'h3; tval = 32'h0; end
      base = csr_mtvec & ~32'h3;
      tgt  = (irq && csr_mtvec[1:0] == 2'b01) ? base + {26'h0, cause[3:0], 2'b00} : base;
      ms   = (csr_mstatus & ~32'h1888) | (csr_mstatus[3] ? 32'h80 : 32'h0) | 32'h1800;
      q.push_back(mk(1'b1, 12'h341, epc,   1'b1, 1'b0, 1'b0, 32'h0));
      q.push_back(mk(1'b1, 12'h342, cause, 1'b0, 1'b0, 1'b0, 32'h0));
      q.push_back(mk(1'b1, 12'h343, tval,  1'b0, 1'b0, 1'b0, 32'h0));
      q.push_back(mk(1'b1, 12'h300, ms,    1'b0, 1'b0, 1'b0, 32'h0));
      q.push_back(mk(1'b0, 12'h0,   32'h0, 1'b0, 1'b0, 1'b1, tgt));
      model_idle = 1'b0;
   endtask

   // Predict for the upcoming edge, compare on the falling edge, then play the
   // CSR file and the requesters' reaction to acks.
   task automatic step();
      predict();
      @(negedge clk);
      cyc++;
      compare();
      #1;
      if (cur_we && cur_addr == 12'h300) csr_mstatus = cur_data;
      if (cur_we && cur_addr == 12'h341) csr_mepc = cur_data;
      if (acc_exc)  begin exc_valid = 1'b0; mret_valid = 1'b0; acc_exc = 1'b0; end
      if (acc_mret) begin mret_valid = 1'b0; acc_mret = 1'b0; end
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      rst = 1'b1;
      exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_tval = '0;
      mret_valid = 1'b0; irq_external = 1'b0; irq_timer = 1'b0; next_pc = '0;
      csr_mstatus = '0; csr_mtvec = '0; csr_mepc = '0; csr_mie_meie = 1'b0; csr_mie_mtie = 1'b0;
      last_addr = '0; last_data = '0; last_rpc = '0;
      model_idle = 1'b1; acc_exc = 1'b0; acc_mret = 1'b0;
      cur_we = 1'b0; cur_addr = '0; cur_data = '0;
      clear_log();
      run(3);
      rst = 1'b0;
      run(2);

      // ecall, vectored mtvec but exception -> base
      clear_log();
      csr_mtvec = 32'h80000001; csr_mstatus = 32'h8;
      exc_valid = 1'b1; exc_code = 4'd11; exc_pc = 32'h80000100; exc_tval = 32'h0;
      run(8);
      chk("ecall_nwrites", 32'(n_log), 32'd4);
      chk("ecall_mepc_addr", 32'(log_addr[0]), 32'h341);
      chk("ecall_mepc", log_data[0], 32'h80000100);
      chk("ecall_mcause", log_data[1], 32'h0000000B);
      chk("ecall_mtval", log_data[2], 32'h0);
      chk("ecall_mstatus_addr", 32'(log_addr[3]), 32'h300);
      chk("ecall_mstatus", log_data[3], 32'h00001880);
      chk("ecall_redirect", rv_pc, 32'h80000000);
      chk("ecall_latency", 32'(rv_cyc - tack_cyc), 32'd4);
      chk("ecall_ack_count", 32'(n_tack), 32'd1);

      // timer interrupt, vectored
      clear_log();
      csr_mstatus = 32'h8; csr_mie_mtie = 1'b1; irq_timer = 1'b1; next_pc = 32'h80000204;
      run(8);
      chk("tmr_mepc", log_data[0], 32'h80000204);
      chk("tmr_mcause", log_data[1], 32'h80000007);
      chk("tmr_mtval", log_data[2], 32'h0);
      chk("tmr_redirect", rv_pc, 32'h8000001C);
      irq_timer = 1'b0;

      // mret
      clear_log();
      csr_mstatus = 32'h1880; csr_mepc = 32'h80000104; mret_valid = 1'b1;
      run(4);
      chk("mret_nwrites", 32'(n_log), 32'd1);
      chk("mret_mstatus", log_data[0], 32'h00001888);
      chk("mret_ack_count", 32'(n_mack), 32'd1);
      chk("mret_redirect", rv_pc, 32'h80000104);
      chk("mret_latency", 32'(rv_cyc - mack_cyc), 32'd1);

      // everything at once: illegal instruction wins, no interrupt afterwards
      clear_log();
      csr_mstatus = 32'h8; csr_mie_meie = 1'b1; csr_mie_mtie = 1'b1;
      irq_external = 1'b1; irq_timer = 1'b1; mret_valid = 1'b1;
      exc_valid = 1'b1; exc_code = 4'd2; exc_pc = 32'h80000302; exc_tval = 32'hDEADBEEF;
      run(12);
      chk("simul_ack_count", 32'(n_tack), 32'd1);
      chk("simul_mret_ack", 32'(n_mack), 32'd0);
      chk("simul_mepc", log_data[0], 32'h80000300);
      chk("simul_mcause", log_data[1], 32'h2);
      chk("simul_mtval", log_data[2], 32'hDEADBEEF);
      irq_external = 1'b0; irq_timer = 1'b0;

      // external masked by MIE=0, then taken over timer
      clear_log();
      csr_mstatus = 32'h0; irq_external = 1'b1;
      run(10);
      chk("masked_ack_count", 32'(n_tack), 32'd0);
      csr_mstatus = 32'h8; irq_timer = 1'b1; csr_mtvec = 32'h80000001;
      run(8);
      chk("ext_mcause", log_data[1], 32'h8000000B);
      chk("ext_redirect", rv_pc, 32'h8000002C);
      irq_external = 1'b0; irq_timer = 1'b0;

      // reset during W_MCAUSE
      clear_log();
      csr_mstatus = 32'h8; exc_valid = 1'b1; exc_code = 4'd11; exc_pc = 32'h80000400;
      run(2);
      rst = 1'b1;
      #1;
      chk("rst_csr_we", 32'(csr_we), 32'd0);
      chk("rst_csr_waddr", 32'(csr_waddr), 32'd0);
      chk("rst_csr_wdata", csr_wdata, 32'd0);
      chk("rst_trap_ack", 32'(trap_ack), 32'd0);
      chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      q.delete();
      last_addr = '0; last_data = '0; last_rpc = '0; model_idle = 1'b1;
      run(2);
      rst = 1'b0;
      run(5);
      clear_log();
      exc_valid = 1'b1; exc_code = 4'd3; exc_pc = 32'h80000500; exc_tval = 32'h12;
      run(8);
      chk("postrst_ack_count", 32'(n_tack), 32'd1);
      chk("postrst_mcause", log_data[1], 32'h3);
      chk("postrst_mtval", log_data[2], 32'h12);

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         if (!exc_valid && $urandom_range(15) == 0) begin
            exc_valid = 1'b1; exc_code = codes[$urandom_range(2)];
            exc_pc = $urandom; exc_tval = $urandom;
         end
         if (!mret_valid && $urandom_range(15) == 0) mret_valid = 1'b1;
         if ($urandom_range(7) == 0) irq_external = ~irq_external;
         if ($urandom_range(7) == 0) irq_timer = ~irq_timer;
         next_pc = $urandom;
         if (model_idle && $urandom_range(5) == 0) begin
            csr_mstatus  = $urandom;
            csr_mtvec    = ($urandom & ~32'h3) | 32'($urandom_range(1));
            csr_mepc     = $urandom;
            csr_mie_meie = 1'($urandom_range(1));
            csr_mie_mtie = 1'($urandom_range(1));
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Machine-mode trap controller for the single-hart RV32 core.
- Arbitrates between four sources: synchronous exceptions from commit (ecall, ebreak, illegal instruction), mret, and external and timer interrupts.
- Sequences the resulting CSR writes one per cycle over the CSR file's single write port, then issues a PC redirect to the fetch stage.
- Holds the pipeline via busy while a trap or return is in flight.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- MTVAL_EN, 1, when 0 the mtval write state is skipped.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- exc_valid  in  1  synchronous exception request; held by commit until trap_ack
- exc_code  in  4  cause code (2 illegal, 3 ebreak, 11 ecall-M)
- exc_pc  in  32  PC of faulting instruction
- exc_tval  in  32  trap value
- mret_valid  in  1  mret committed; held until mret_ack
- irq_external  in  1  level interrupt
- irq_timer  in  1  level interrupt
- next_pc  in  32  PC to resume at after an interrupt
- csr_mstatus  in  32  current mstatus
- csr_mie_meie  in  1  mie.MEIE
- csr_mie_mtie  in  1  mie.MTIE
- csr_mtvec  in  32  current mtvec
- csr_mepc  in  32  current mepc
- csr_we  out  1  CSR write strobe
- csr_waddr  out  12  CSR address
- csr_wdata  out  32  CSR write data
- trap_ack  out  1  one-cycle pulse: trap accepted
- mret_ack  out  1  one-cycle pulse: mret accepted
- redirect_valid  out  1  one-cycle pulse
- redirect_pc  out  32  redirect target
- busy  out  1  pipeline hold

Behaviour:
- Reset (async): state=IDLE; all outputs and capture registers 0. Reset in any state aborts the sequence; no further csr_we is issued.
- All outputs are registered except busy, which is (state != IDLE) decoded from the state register.
- Requests are sampled only in IDLE. Requests arriving while busy are not accepted.
- Priority in IDLE:
  1. exc_valid
  2. mret_valid
  3. irq_external, gated by mstatus[3] & meie
  4. irq_timer, gated by mstatus[3] & mtie
- Simultaneous exc_valid and mret_valid: the exception wins; mret is not acked and is squashed upstream by the trap flush.
- Capture on acceptance edge:
  - epc: exception uses {exc_pc[31:2],2'b00}; interrupt uses {next_pc[31:2],2'b00}.
  - cause: exception is {28'b0,exc_code}; external is 0x8000000B; timer is 0x80000007.
  - tval: exc_tval for exceptions, 0 for interrupts.
  - target: base={mtvec[31:2],2'b00}; if mtvec[1:0]==01 and the trap is an interrupt, target = base + 4*cause[3:0]; otherwise target = base.
  - mstatus_new: MPIE(bit7)=MIE(bit3); MIE=0; MPP(12:11)=11; other bits unchanged.
- Trap FSM: IDLE -> W_MEPC -> W_MCAUSE -> W_MTVAL -> W_MSTATUS -> REDIRECT -> IDLE.
  - W_MEPC: csr_we=1, waddr 0x341, data epc; trap_ack=1 this cycle.
  - W_MCAUSE: 0x342, cause.
  - W_MTVAL: 0x343, tval. Skipped when MTVAL_EN=0.
  - W_MSTATUS: 0x300, mstatus_new.
  - REDIRECT: redirect_valid=1, redirect_pc=target, csr_we=0.
- Trap latency: 5 cycles from the acceptance edge to redirect_valid (4 when MTVAL_EN=0).
- mret FSM: IDLE -> R_MSTATUS -> REDIRECT -> IDLE.
  - R_MSTATUS: mret_ack=1; write 0x300 with MIE=MPIE, MPIE=1, MPP=11, other bits unchanged.
  - REDIRECT: redirect_pc = csr_mepc captured at acceptance.
- csr_waddr/csr_wdata hold their last values when csr_we=0. redirect_pc holds when redirect_valid=0.
- The block does not read back CSRs mid-sequence. A new request is evaluated against CSR inputs in the IDLE cycle after REDIRECT.
- Gating uses the mstatus value present in IDLE. The trap itself clears MIE, so back-to-back interrupts are blocked by the CSR file's update.

Test Plan:
- Ecall: exc_code=11, exc_pc=0x80000100, exc_tval=0, mtvec=0x80000001, mstatus=0x00000008 -> writes 0x341=0x80000100, 0x342=0x0000000B, 0x343=0, 0x300=0x00001880; redirect_pc=0x80000000 five cycles after acceptance; trap_ack pulses once.
- Timer interrupt: mstatus=0x8, mtie=1, irq_timer=1, next_pc=0x80000204, mtvec=0x80000001 -> 0x341=0x80000204, 0x342=0x80000007, 0x343=0; redirect_pc=0x8000001C.
- mret: mstatus=0x1880, mepc=0x80000104 -> single write 0x300=0x00001888; mret_ack pulse; redirect_pc=0x80000104 two cycles after acceptance.
- Simultaneous exc_valid (code 2), mret_valid, irq_external and irq_timer with MIE=1 -> illegal-instruction trap only (mcause=2); mret_ack stays 0; with the CSR model applying MIE=0, no interrupt is taken on return to IDLE.
- irq_external=1 with mstatus.MIE=0 -> no ack and busy=0 for 10 cycles. Set MIE=1 with irq_timer also high -> external taken: mcause=0x8000000B, redirect base+0x2C.
- Reset asserted during W_MCAUSE -> all outputs 0 immediately, no further csr_we or redirect. After release, busy=0 and a new exc_valid is accepted normally.
